// File: rtl/ddr_arbiter.sv
// Arbitrates fetch, load and store requesters onto a single DDR port, one transaction at a time.
// Priority is store > load > fetch, with a fetch override after STARVE_LIMIT grants and a WAIT timeout.
module ddr_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 1024
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          fetch_req,
   input  logic [18:0]   fetch_index,
   output logic          fetch_done,
   output logic [511:0]  fetch_inst,
   input  logic          load_req,
   input  logic [18:0]   load_index,
   output logic          load_done,
   output logic [63:0]   load_data,
   input  logic          store_req,
   input  logic [18:0]   store_index,
   input  logic [63:0]   store_mask,
   input  logic [63:0]   store_data,
   output logic          store_done,
   output logic          err_timeout,
   output logic          ddr_chip_enable,
   output logic          ddr_write_enable,
   output logic          ddr_burst_mode,
   output logic [18:0]   ddr_index,
   output logic [63:0]   ddr_opstore_write_mask,
   output logic [63:0]   ddr_opstore_write_data,
   input  logic [63:0]   ddr_opload_read_data,
   input  logic [511:0]  ddr_pc_read_inst,
   input  logic          ddr_operation_done,
   input  logic          ddr_ready
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_FETCH, SRC_LOAD, SRC_STORE} src_t;

   typedef struct packed {
      logic        we;
      logic        burst;
      logic [18:0] index;
      logic [63:0] mask;
      logic [63:0] data;
   } ddr_cmd_t;

   state_t          state, state_nxt;
   src_t            sel, gnt;
   ddr_cmd_t        cmd_nxt;
   logic            finish, tmo, any_done;
   logic [SW-1:0]   starve_cnt;
   logic [WW-1:0]   wait_cnt;

   // The IDLE cycle carrying a done pulse never grants, so a requester that
   // still shows its old req in that cycle is not issued twice.
   assign any_done = fetch_done | load_done | store_done;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sel       = SRC_NONE;
      finish    = 1'b0;
      tmo       = 1'b0;
      case (state)
         IDLE: begin
            if (ddr_ready && !any_done && (fetch_req || load_req || store_req)) begin
               state_nxt = WAIT;
               if (fetch_req && starve_cnt == STARVE_MAX) sel = SRC_FETCH;
               else if (store_req)                        sel = SRC_STORE;
               else if (load_req)                         sel = SRC_LOAD;
               else                                       sel = SRC_FETCH;
            end
         end
         WAIT: begin
            if (ddr_operation_done) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               finish    = 1'b1;
               tmo       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_nxt = '0;
      case (sel)
         SRC_FETCH: begin
            cmd_nxt.burst = 1'b1;
            cmd_nxt.index = fetch_index;
         end
         SRC_LOAD:  cmd_nxt.index = load_index;
         SRC_STORE: begin
            cmd_nxt.we    = 1'b1;
            cmd_nxt.index = store_index;
            cmd_nxt.mask  = store_mask;
            cmd_nxt.data  = store_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt                    <= SRC_NONE;
         starve_cnt             <= '0;
         wait_cnt               <= '0;
         ddr_chip_enable        <= 1'b0;
         ddr_write_enable       <= 1'b0;
         ddr_burst_mode         <= 1'b0;
         ddr_index              <= '0;
         ddr_opstore_write_mask <= '0;
         ddr_opstore_write_data <= '0;
         fetch_done             <= 1'b0;
         load_done              <= 1'b0;
         store_done             <= 1'b0;
         fetch_inst             <= '0;
         load_data              <= '0;
         err_timeout            <= 1'b0;
      end else begin
         ddr_chip_enable <= (sel != SRC_NONE);
         fetch_done      <= 1'b0;
         load_done       <= 1'b0;
         store_done      <= 1'b0;
         if (sel != SRC_NONE) begin
            gnt                    <= sel;
            wait_cnt               <= '0;
            ddr_write_enable       <= cmd_nxt.we;
            ddr_burst_mode         <= cmd_nxt.burst;
            ddr_index              <= cmd_nxt.index;
            ddr_opstore_write_mask <= cmd_nxt.mask;
            ddr_opstore_write_data <= cmd_nxt.data;
            if (sel == SRC_FETCH)
               starve_cnt <= '0;
            else if (fetch_req && starve_cnt != STARVE_MAX)
               starve_cnt <= starve_cnt + 1'b1;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         // A timed-out transaction still completes its requester, but leaves data untouched.
         if (finish) begin
            if (tmo) err_timeout <= 1'b1;
            case (gnt)
               SRC_FETCH: begin
                  fetch_done <= 1'b1;
                  if (!tmo) fetch_inst <= ddr_pc_read_inst;
               end
               SRC_LOAD: begin
                  load_done <= 1'b1;
                  if (!tmo) load_data <= ddr_opload_read_data;
               end
               SRC_STORE: store_done <= 1'b1;
               default: ;
            endcase
         end
      end
   end
endmodule
